// File: rtl/ift_mmio_responder.sv
// Taint-tracked MMIO responder: scratch register, cycle counter, console byte FIFO and stop register.
// Optional MMIO_ADDR_TAINT_EN: tainted address bits taint read data, scratch and pushed console bytes.
module ift_mmio_responder #(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = 32'h1000_0000,
    parameter int unsigned          FifoDepth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   mmio_req_i,
    input  logic                   mmio_we_i,
    input  logic [AddrWidth-1:0]   mmio_addr_i,
    input  logic [DataWidth-1:0]   mmio_wdata_i,
    input  logic [DataWidth/8-1:0] mmio_strb_i,
    output logic [DataWidth-1:0]   mmio_rdata_o,

    input  logic                   mmio_req_i_t0,
    input  logic                   mmio_we_i_t0,
    input  logic [AddrWidth-1:0]   mmio_addr_i_t0,
    input  logic [DataWidth-1:0]   mmio_wdata_i_t0,
    input  logic [DataWidth/8-1:0] mmio_strb_i_t0,
    output logic [DataWidth-1:0]   mmio_rdata_o_t0,

    output logic                   cons_valid_o,
    input  logic                   cons_ready_i,
    output logic [7:0]             cons_data_o,
    output logic [7:0]             cons_data_o_t0,

    output logic                   stop_o,
    output logic [31:0]            stop_code_o
);

    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned StrbW = DataWidth / 8;

    localparam logic [1:0] RegScratch = 2'd0;
    localparam logic [1:0] RegCycle   = 2'd1;
    localparam logic [1:0] RegConsole = 2'd2;
    localparam logic [1:0] RegStop    = 2'd3;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       hit;
    logic       rd_req;
    logic       wr_req;
    logic       wr_hit;
    logic [1:0] reg_sel;
    logic       addr_tainted;

    assign hit     = mmio_req_i && (mmio_addr_i[AddrWidth-1:5] == BaseAddr[AddrWidth-1:5]);
    assign reg_sel = mmio_addr_i[4:3];
    assign rd_req  = mmio_req_i && !mmio_we_i;
    assign wr_req  = mmio_req_i && mmio_we_i;
    assign wr_hit  = hit && mmio_we_i;

`ifdef MMIO_ADDR_TAINT_EN
    assign addr_tainted = |mmio_addr_i_t0[AddrWidth-1:3];
`else
    assign addr_tainted = 1'b0;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{mmio_addr_i[2:0], mmio_addr_i_t0};

    // ------------------------------------------------------------------
    // SCRATCH register and its byte-wise taint
    // ------------------------------------------------------------------
    logic [DataWidth-1:0] scratch_q;
    logic [DataWidth-1:0] scratch_t0_q;
    logic [DataWidth-1:0] scratch_d;
    logic [DataWidth-1:0] scratch_t0_d;

    always_comb begin
        scratch_d    = scratch_q;
        scratch_t0_d = scratch_t0_q;
        if (wr_hit && (reg_sel == RegScratch)) begin
            for (int i = 0; i < StrbW; i++) begin
                if (mmio_strb_i[i]) begin
                    scratch_d[8*i +: 8]    = mmio_wdata_i[8*i +: 8];
                    scratch_t0_d[8*i +: 8] = mmio_wdata_i_t0[8*i +: 8];
                end
                // A tainted enable makes the byte's content uncertain either way.
                if (mmio_strb_i_t0[i]) begin
                    scratch_t0_d[8*i +: 8] = 8'hFF;
                end
            end
            if (mmio_req_i_t0 || mmio_we_i_t0) begin
                scratch_t0_d = '1;
            end
        end
        // A tainted address could have aimed the write at SCRATCH, wherever it decoded.
        if (wr_req && addr_tainted) begin
            scratch_t0_d = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scratch_q    <= '0;
            scratch_t0_q <= '0;
        end else begin
            scratch_q    <= scratch_d;
            scratch_t0_q <= scratch_t0_d;
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycle counter
    // ------------------------------------------------------------------
    logic [63:0] cycle_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // Handshake: the head byte transfers on every cycle where cons_valid_o
    // and cons_ready_i are both high; while valid is high and ready is low
    // the head data and taint hold steady and valid never drops.
    // ------------------------------------------------------------------
    logic [7:0]      fifo_data_q [FifoDepth];
    logic [7:0]      fifo_t0_q   [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] fill_q;
    logic [15:0]     dropped_q;

    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            drop;
    logic [7:0]      push_t0;

    assign full     = (fill_q == CntW'(FifoDepth));
    assign pop      = cons_valid_o && cons_ready_i;
    assign push_req = wr_hit && (reg_sel == RegConsole) && mmio_strb_i[0];
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && !push;
    assign push_t0  = addr_tainted ? 8'hFF : mmio_wdata_i_t0[7:0];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mmio_wdata_i[7:0];
            fifo_t0_q[wr_ptr_q]   <= push_t0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            dropped_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
            if (drop && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign cons_valid_o   = (fill_q != '0);
    assign cons_data_o    = cons_valid_o ? fifo_data_q[rd_ptr_q] : 8'h00;
    assign cons_data_o_t0 = cons_valid_o ? fifo_t0_q[rd_ptr_q]   : 8'h00;

    // ------------------------------------------------------------------
    // STOP register: first strobed write wins until reset
    // ------------------------------------------------------------------
    logic        stop_q;
    logic [31:0] stop_code_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stop_q      <= 1'b0;
            stop_code_q <= '0;
        end else if (wr_hit && (reg_sel == RegStop) && mmio_strb_i[0] && !stop_q) begin
            stop_q      <= 1'b1;
            stop_code_q <= mmio_wdata_i[31:0];
        end
    end

    assign stop_o      = stop_q;
    assign stop_code_o = stop_code_q;

    // ------------------------------------------------------------------
    // Read path: one registered response per read, held until the next read
    // ------------------------------------------------------------------
    logic [DataWidth-1:0] rdata_d;
    logic [DataWidth-1:0] rdata_t0_d;
    logic [DataWidth-1:0] rdata_q;
    logic [DataWidth-1:0] rdata_t0_q;

    always_comb begin
        rdata_d    = '0;
        rdata_t0_d = '0;
        if (hit) begin
            case (reg_sel)
                RegScratch: begin
                    rdata_d    = scratch_q;
                    rdata_t0_d = scratch_t0_q;
                end
                RegCycle:   rdata_d = cycle_q;
                RegConsole: rdata_d = {16'b0, dropped_q, {(32-CntW){1'b0}}, fill_q};
                RegStop:    rdata_d = {{(DataWidth-1){1'b0}}, stop_q};
                default:    rdata_d = '0;
            endcase
            // A tainted strobe or direction means the response itself may not exist.
            if (mmio_req_i_t0 || mmio_we_i_t0) begin
                rdata_t0_d = '1;
            end
        end
        if (addr_tainted) begin
            rdata_t0_d = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q    <= '0;
            rdata_t0_q <= '0;
        end else if (rd_req) begin
            rdata_q    <= rdata_d;
            rdata_t0_q <= rdata_t0_d;
        end
    end

    assign mmio_rdata_o    = rdata_q;
    assign mmio_rdata_o_t0 = rdata_t0_q;

endmodule
